// File: rtl/input_memory_manager.sv
// Input memory manager: streams (activation, weight) operand pairs from two RAMs to an 8-neuron accumulator.
// Latency: an operand pair appears two cycles after its read is issued; the first pair arrives three cycles after start.
// Backpressure: hold stalls new read issue in READ only; reads already in flight always complete.
module input_memory_manager (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic        hold,
  input  logic [4:0]  num_elements,
  output logic [3:0]  z_ram_address,
  output logic        z_ram_enable,
  input  logic [15:0] z_ram_data,
  output logic [6:0]  m_ram_address,
  output logic        m_ram_enable,
  input  logic [15:0] m_ram_data,
  output logic [15:0] active_z,
  output logic [15:0] active_m,
  output logic        next_element,
  output logic        last_element,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, FLUSH, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  n_lat;       // latched element count, already clamped to 0..16
  logic [4:0]  n_clamp;
  logic [3:0]  elem_i;      // outer index: input element
  logic [2:0]  nrn_j;       // inner index: neuron
  logic [2:0]  flush_cnt;
  logic        rd_vld;      // a read issued last cycle; RAM data is valid now
  logic        issue;
  logic        final_issue;
  logic        accept_start;

  // Decode issue conditions, clamp the requested length and drive RAM ports.
  always_comb begin
    n_clamp       = (num_elements > 5'd16) ? 5'd16 : num_elements;
    accept_start  = ((state == IDLE) || (state == DONE)) && start;
    issue         = (state == READ) && !hold;
    final_issue   = issue && ({1'b0, elem_i} == (n_lat - 5'd1)) && (nrn_j == 3'd7);
    z_ram_enable  = issue;
    m_ram_enable  = issue;
    z_ram_address = issue ? elem_i : 4'd0;
    m_ram_address = issue ? {elem_i, nrn_j} : 7'd0;
    busy          = (state == READ) || (state == DRAIN) || (state == FLUSH);
    done          = (state == DONE);
    last_element  = (state == FLUSH);
  end

  // Next-state logic for the pass sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = (n_clamp == 5'd0) ? FLUSH : READ;
      end
      READ: begin
        if (final_issue) state_nxt = DRAIN;
      end
      DRAIN: begin
        // The final read lands in the first DRAIN cycle; leave once its pulse is out.
        if (next_element && !rd_vld) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (flush_cnt == 3'd7) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= state_nxt;
  end

  // Element/neuron walk, length latch and flush window counter.
  always_ff @(posedge clock) begin
    if (clear) begin
      n_lat     <= 5'd0;
      elem_i    <= 4'd0;
      nrn_j     <= 3'd0;
      flush_cnt <= 3'd0;
    end else if (accept_start) begin
      n_lat     <= n_clamp;
      elem_i    <= 4'd0;
      nrn_j     <= 3'd0;
      flush_cnt <= 3'd0;
    end else begin
      if (issue) begin
        nrn_j <= nrn_j + 3'd1;
        if (nrn_j == 3'd7) elem_i <= elem_i + 4'd1;
      end
      if (state == FLUSH) flush_cnt <= flush_cnt + 3'd1;
    end
  end

  // Read-return pipeline: capture RAM data one cycle after issue and flag it as a valid operand pair.
  always_ff @(posedge clock) begin
    if (clear) begin
      rd_vld       <= 1'b0;
      next_element <= 1'b0;
      active_z     <= 16'd0;
      active_m     <= 16'd0;
    end else begin
      rd_vld       <= issue;
      next_element <= rd_vld;
      if (rd_vld) begin
        active_z <= z_ram_data;
        active_m <= m_ram_data;
      end
    end
  end

endmodule
